// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg                                                          |
// | Shared types and constants for the IF/LS memory port arbiter.        |
// |   owner_e        : tag recording which requester owns the response   |
// |   BE_W, BE_FULL  : byte-enable width and all-lanes mask              |
// |   STARVE_W       : width of the IF starvation counter                |
// |   STARVE_MAX_DEF : default starvation threshold                      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

   localparam int BE_W           = 4;
   localparam logic [BE_W-1:0] BE_FULL = 4'b1111;
   localparam int STARVE_W       = 3;
   localparam int STARVE_MAX_DEF = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } owner_e;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_prio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_prio                                                         |
// | Per-cycle grant decision between instruction fetch and load/store,   |
// | LS first, with a saturating starvation counter that hands IF one     |
// | grant after STARVE_MAX consecutive denied cycles.                    |
// | Ports:                                                               |
// |   clk, rst_n     : clock, asynchronous active-low reset              |
// |   if_req_valid   : IF request pending                                |
// |   ls_req_valid   : LS request pending                                |
// |   grant_if       : IF owns the memory port this cycle                |
// |   grant_ls       : LS owns the memory port this cycle                |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic if_req_valid,
   input  logic ls_req_valid,
   output logic grant_if,
   output logic grant_ls
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   logic [STARVE_W-1:0] starve_cnt;
   logic                starved;

   assign starved = (starve_cnt == STARVE_LIM) && if_req_valid;

   // Grants are qualified by rst_n so nothing is accepted while the
   // block is held in reset.
   always_comb begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (rst_n) begin
         if (starved)
            grant_if = 1'b1;
         else if (ls_req_valid)
            grant_ls = 1'b1;
         else if (if_req_valid)
            grant_if = 1'b1;
      end
   end

   // Counts consecutive cycles in which IF was waiting but not served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_cnt <= '0;
      else if (!if_req_valid || grant_if)
         starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM)
         starve_cnt <= starve_cnt + 1'b1;
   end

endmodule : mem_arb_prio
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter                                                     |
// | Shares a single-ported 32-word memory between instruction fetch (IF) |
// | and load/store (LS). One access per cycle; each access is tagged so  |
// | its 1-cycle-latency read data returns to the right requester.        |
// | Ports:                                                               |
// |   clk, rst_n               : clock, asynchronous active-low reset    |
// |   if_req_*                 : IF read request handshake + address     |
// |   if_rsp_*                 : IF read data return                     |
// |   ls_req_*                 : LS request handshake, we/be/addr/wdata  |
// |   ls_rsp_*                 : LS load data or store acknowledge       |
// |   mem_*                    : memory array strobe/write/addr/data     |
// |   perf_conflicts           : (optional) cycles with both requesting  |
// |   perf_starve_wins         : (optional) IF grants forced by starving |
// | Optional feature macro: MEM_PORT_ARBITER_PERF_EN                     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_rsp_valid,
   output logic [DATA_W-1:0] if_rsp_data,
   input  logic              ls_req_valid,
   output logic              ls_req_ready,
   input  logic              ls_req_we,
   input  logic [BE_W-1:0]   ls_req_be,
   input  logic [ADDR_W-1:0] ls_req_addr,
   input  logic [DATA_W-1:0] ls_req_wdata,
   output logic              ls_rsp_valid,
   output logic [DATA_W-1:0] ls_rsp_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [BE_W-1:0]   mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_PORT_ARBITER_PERF_EN
   ,
   output logic [15:0]       perf_conflicts,
   output logic [15:0]       perf_starve_wins
`endif
);

   logic   grant_if;
   logic   grant_ls;
   owner_e owner;
   logic   owner_store;

   mem_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req_valid (if_req_valid),
      .ls_req_valid (ls_req_valid),
      .grant_if     (grant_if),
      .grant_ls     (grant_ls)
   );

   assign if_req_ready = grant_if;
   assign ls_req_ready = grant_ls;

   // Memory drive; loads always read the full word.
   always_comb begin
      mem_en    = grant_if | grant_ls;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_ls) begin
         mem_we    = ls_req_we;
         mem_be    = ls_req_we ? ls_req_be : BE_FULL;
         mem_addr  = ls_req_addr;
         mem_wdata = ls_req_wdata;
      end else if (grant_if) begin
         mem_be    = BE_FULL;
         mem_addr  = if_req_addr;
      end
   end

   // Response tag: who owns the data the memory returns next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner       <= OWN_NONE;
         owner_store <= 1'b0;
      end else begin
         if (grant_ls)
            owner <= OWN_LS;
         else if (grant_if)
            owner <= OWN_IF;
         else
            owner <= OWN_NONE;
         owner_store <= grant_ls & ls_req_we;
      end
   end

   assign if_rsp_valid = (owner == OWN_IF);
   assign ls_rsp_valid = (owner == OWN_LS);
   assign if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
   // Stores acknowledge with zero data rather than stale read data.
   assign ls_rsp_data  = (ls_rsp_valid && !owner_store) ? mem_rdata : '0;

`ifdef MEM_PORT_ARBITER_PERF_EN
   // IF can only win while LS is requesting through starvation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_conflicts   <= '0;
         perf_starve_wins <= '0;
      end else begin
         if (if_req_valid && ls_req_valid && (perf_conflicts != 16'hFFFF))
            perf_conflicts <= perf_conflicts + 16'd1;
         if (grant_if && ls_req_valid && (perf_starve_wins != 16'hFFFF))
            perf_starve_wins <= perf_starve_wins + 16'd1;
      end
   end
`endif

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                  |
// | Self-checking bench: directed scenarios then random traffic. The     |
// | driver predicts grants/memory drive and pushes expected responses    |
// | into per-requester queues; a monitor pops them as responses appear.  |
// | Optional feature macro: MEM_PORT_ARBITER_PERF_EN                     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_mem_port_arbiter;

   localparam int STARVE_MAX = 4;

   typedef struct {
      logic [31:0] data;
      int          due;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req_valid = 1'b0;
   logic        if_req_ready;
   logic [4:0]  if_req_addr = '0;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;
   logic        ls_req_valid = 1'b0;
   logic        ls_req_ready;
   logic        ls_req_we = 1'b0;
   logic [3:0]  ls_req_be = '0;
   logic [4:0]  ls_req_addr = '0;
   logic [31:0] ls_req_wdata = '0;
   logic        ls_rsp_valid;
   logic [31:0] ls_rsp_data;
   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
`ifdef MEM_PORT_ARBITER_PERF_EN
   logic [15:0] perf_conflicts;
   logic [15:0] perf_starve_wins;
   int          m_conflicts = 0;
   int          m_starve_wins = 0;
`endif

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W     (5),
      .DATA_W     (32),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req_valid (if_req_valid),
      .if_req_ready (if_req_ready),
      .if_req_addr  (if_req_addr),
      .if_rsp_valid (if_rsp_valid),
      .if_rsp_data  (if_rsp_data),
      .ls_req_valid (ls_req_valid),
      .ls_req_ready (ls_req_ready),
      .ls_req_we    (ls_req_we),
      .ls_req_be    (ls_req_be),
      .ls_req_addr  (ls_req_addr),
      .ls_req_wdata (ls_req_wdata),
      .ls_rsp_valid (ls_rsp_valid),
      .ls_rsp_data  (ls_rsp_data),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_be       (mem_be),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
`ifdef MEM_PORT_ARBITER_PERF_EN
      ,
      .perf_conflicts   (perf_conflicts),
      .perf_starve_wins (perf_starve_wins)
`endif
   );

   // Environment memory (the array the arbiter drives) and the
   // bench's own reference copy of its expected contents.
   logic [31:0] mem     [32];
   logic [31:0] ref_mem [32];
   rsp_t        if_q [$];
   rsp_t        ls_q [$];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          if_wait = 0;
   logic        exp_gi, exp_gl;

   function automatic logic [31:0] merge(input logic [31:0] old_w,
                                         input logic [31:0] new_w,
                                         input logic [3:0]  be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_en) begin
         if (mem_we)
            mem[mem_addr] = merge(mem[mem_addr], mem_wdata, mem_be);
         else
            mem_rdata <= mem[mem_addr];
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_ctrl"}, 128'({if_req_ready, ls_req_ready, mem_en, mem_we, mem_be,
                               mem_addr, if_rsp_valid, ls_rsp_valid}), 128'(0));
      chk({nm, "_data"}, 128'({mem_wdata, if_rsp_data, ls_rsp_data}), 128'(0));
   endtask

   // Drive one cycle of requests, predict the arbitration from the
   // priority/starvation rules and check the combinational response.
   task automatic step(input logic iv, input logic [4:0] ia, input logic lv,
                       input logic lwe, input logic [3:0] lbe, input logic [4:0] la,
                       input logic [31:0] lwd);
      logic [3:0]  e_be;
      logic [4:0]  e_addr;
      @(negedge clk);
      if_req_valid = iv;  if_req_addr = ia;
      ls_req_valid = lv;  ls_req_we = lwe; ls_req_be = lbe;
      ls_req_addr  = la;  ls_req_wdata = lwd;
      #1;
      exp_gi = 1'b0;
      exp_gl = 1'b0;
      if (iv && if_wait >= STARVE_MAX) exp_gi = 1'b1;
      else if (lv)                     exp_gl = 1'b1;
      else if (iv)                     exp_gi = 1'b1;
      e_be   = exp_gl ? (lwe ? lbe : 4'hF) : (exp_gi ? 4'hF : 4'h0);
      e_addr = exp_gl ? la : (exp_gi ? ia : 5'd0);
      chk("if_ready", 128'(if_req_ready), 128'(exp_gi));
      chk("ls_ready", 128'(ls_req_ready), 128'(exp_gl));
      chk("mem_ctrl", 128'({mem_en, mem_we, mem_be, mem_addr}),
          128'({exp_gi | exp_gl, exp_gl & lwe, e_be, e_addr}));
      chk("mem_wdata", 128'(mem_wdata), 128'(exp_gl ? lwd : 32'd0));
`ifdef MEM_PORT_ARBITER_PERF_EN
      if (iv && lv) m_conflicts++;
      if (exp_gi && lv) m_starve_wins++;
`endif
      if_wait = (iv && !exp_gi) ? if_wait + 1 : 0;
      if (exp_gi) if_q.push_back('{ref_mem[ia], cyc + 1});
      if (exp_gl) begin
         if (lwe) begin
            ref_mem[la] = merge(ref_mem[la], lwd, lbe);
            ls_q.push_back('{32'd0, cyc + 1});
         end else begin
            ls_q.push_back('{ref_mem[la], cyc + 1});
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic model_reset();
      if_q.delete();
      ls_q.delete();
      if_wait = 0;
`ifdef MEM_PORT_ARBITER_PERF_EN
      m_conflicts = 0;
      m_starve_wins = 0;
`endif
   endtask

   // Monitor: responses must appear exactly one cycle after the grant.
   always @(negedge clk) begin
      logic ev_if, ev_ls;
      #2;
      if (rst_n) begin
         ev_if = (if_q.size() > 0) && (if_q[0].due == cyc);
         ev_ls = (ls_q.size() > 0) && (ls_q[0].due == cyc);
         chk("if_rsp_valid", 128'(if_rsp_valid), 128'(ev_if));
         chk("ls_rsp_valid", 128'(ls_rsp_valid), 128'(ev_ls));
         if (ev_if) begin
            chk("if_rsp_data", 128'(if_rsp_data), 128'(if_q[0].data));
            void'(if_q.pop_front());
         end
         if (ev_ls) begin
            chk("ls_rsp_data", 128'(ls_rsp_data), 128'(ls_q[0].data));
            void'(ls_q.pop_front());
         end
         if (!ev_if && !ev_ls)
            chk("rsp_idle_data", 128'({if_rsp_data, ls_rsp_data}), 128'(0));
      end
   end

   initial begin
      logic [14:0] pat;
      logic        ip, lp, lwe;
      logic [4:0]  ia, la;
      logic [3:0]  lbe;
      logic [31:0] lwd;

      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      mem[0] = 32'h0000_0022;
      mem[1] = 32'h0000_0011;
      mem[2] = 32'h00A0_0093;
      mem[5] = 32'h1234_5678;
      mem[7] = 32'hCAFE_F00D;
      for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];

      // Reset with both requesters asserting: nothing may be accepted.
      if_req_valid = 1'b1;
      ls_req_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk_all_zero("reset_outputs");
      @(negedge clk);
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      rst_n = 1'b1;
      idle(2);

      // IF alone: fetch of addr 2.
      step(1, 5'd2, 0, 0, 0, 0, 0);
      idle(2);

      // Reset between an IF grant and its response cycle.
      step(1, 5'd3, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      if_req_valid = 1'b1;
      ls_req_valid = 1'b1;
      #1;
      chk_all_zero("reset_midread");
      @(negedge clk);
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      rst_n = 1'b1;
      idle(3);

      // Partial store then load of the same word.
      step(0, 0, 1, 1, 4'b0011, 5'd5, 32'h0000_BEEF);
      step(0, 0, 1, 0, 4'b0000, 5'd5, 32'h0);
      idle(2);

      // Continuous contention: IF wins every fifth cycle.
      for (int i = 0; i < 15; i++) begin
         step(1, 5'd4, 1, 0, 4'hF, 5'd6, 32'h0);
         pat[i] = if_req_ready;
      end
      chk("contention_pattern", 128'(pat), 128'(15'b100001000010000));
      idle(2);

      // Back-to-back alternating owners.
      step(0, 0, 1, 0, 4'hF, 5'd1, 32'h0);
      step(1, 5'd0, 0, 0, 0, 0, 0);
      idle(2);

      // Zero-byte store: acknowledged, memory untouched.
      step(0, 0, 1, 1, 4'b0000, 5'd7, 32'h1111_2222);
      idle(1);
      chk("zero_be_mem", 128'(mem[7]), 128'(32'hCAFE_F00D));
      step(0, 0, 1, 0, 4'b0000, 5'd7, 32'h0);
      idle(2);

      // Random traffic; requests stay stable until accepted.
      ip = 1'b0; lp = 1'b0; lwe = 1'b0;
      ia = '0; la = '0; lbe = '0; lwd = '0;
      for (int n = 0; n < 400; n++) begin
         if (!ip) begin
            ip = ($urandom_range(0, 2) != 0);
            ia = 5'($urandom_range(0, 31));
         end
         if (!lp) begin
            lp  = ($urandom_range(0, 1) != 0);
            lwe = ($urandom_range(0, 1) != 0);
            lbe = 4'($urandom_range(0, 15));
            la  = 5'($urandom_range(0, 31));
            lwd = $urandom;
         end
         step(ip, ia, lp, lwe, lbe, la, lwd);
         if (exp_gi) ip = 1'b0;
         if (exp_gl) lp = 1'b0;
      end
      idle(3);

      chk("queues_drained", 128'(if_q.size() + ls_q.size()), 128'(0));
`ifdef MEM_PORT_ARBITER_PERF_EN
      chk("perf_conflicts", 128'(perf_conflicts), 128'(m_conflicts));
      chk("perf_starve_wins", 128'(perf_starve_wins), 128'(m_starve_wins));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mem_port_arbiter
`default_nettype wire
